column_output_drain: RTL and testbench
======================================

COLUMN_OUTPUT_DRAIN -- requirements
Module: column_output_drain

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator width in bits (at least 28).
REQ-002 SHALL have parameter OUT_W, default 16, output word width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries (power of two).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  job start pulse; sampled in IDLE only.
REQ-007 SHALL have port tile_count  input  8  partial sums per output; latched at start.
REQ-008 SHALL have port num_outputs  input  8  outputs per job; latched at start.
REQ-009 SHALL have port shift_amt  input  5  arithmetic right shift applied at emit; latched at start.
REQ-010 SHALL have port relu_en  input  1  clamp negatives to 0; latched at start.
REQ-011 SHALL have port total_output  input  28  signed column partial sum.
REQ-012 SHALL have port in_valid  input  1  total_output valid.
REQ-013 SHALL have port in_ready  output  1  partial sum accepted when in_valid and in_ready are both high.
REQ-014 SHALL have port out_data  output  OUT_W  FIFO head, signed.
REQ-015 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-016 SHALL have port out_ready  input  1  consumer pops head when out_valid and out_ready are both high.
REQ-017 SHALL have port busy  output  1  state is not IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse after the last output is pushed.

Function
REQ-019 SHALL implement FSM states IDLE, ACCUM, EMIT.
REQ-020 SHALL move IDLE->ACCUM on start when tile_count!=0 and num_outputs!=0; otherwise start SHALL be ignored.
REQ-021 SHALL assert in_ready only in ACCUM.
REQ-022 SHALL sign-extend each accepted total_output to ACC_W and add it to the accumulator; the first beat of each output SHALL load the accumulator instead of adding.
REQ-023 SHALL move ACCUM->EMIT in the cycle after the tile_count-th accepted beat.
REQ-024 In EMIT, SHALL compute r = acc >>> shift_amt, then set r=0 if relu_en and r<0, then saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-025 SHALL push r into the FIFO in EMIT when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise SHALL stall in EMIT.
REQ-026 After a push, SHALL go to ACCUM if outputs pushed < num_outputs; otherwise SHALL pulse done and go to IDLE.
REQ-027 SHALL ignore in_valid outside ACCUM; no beat is consumed.
REQ-028 SHALL present the FIFO head on out_data with zero-cycle latency from out_valid.
REQ-029 SHALL drive out_data to 0 when the FIFO is empty.
REQ-030 SHALL keep FIFO contents across jobs; a new start SHALL NOT flush the FIFO.
REQ-031 SHALL ignore start while busy.
REQ-032 SHALL give a latency of 1 cycle from the last accepted beat to the FIFO push when not stalled, with out_valid high on the following cycle.

Reset
REQ-033 On reset, SHALL enter IDLE, empty the FIFO, clear the accumulator and counters, and drive in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-034 Reset mid-job SHALL abort the job with no done pulse; reset SHALL take priority over all other inputs.

Configuration
REQ-035 With macro COLUMN_DRAIN_ROUND_EN defined, SHALL add 2^(shift_amt-1) to acc before the shift when shift_amt>0 (round half up).
REQ-036 Without COLUMN_DRAIN_ROUND_EN, SHALL truncate toward negative infinity (plain arithmetic shift).

Verification
REQ-037 start with tile_count=3, num_outputs=1, shift=0, relu=0; beats 10, -4, 7 -> single out_data=13, done pulse one cycle after the push.
REQ-038 tile_count=1, shift=2, relu=1; beats -100, 7 -> outputs 0 and 1 (2 with COLUMN_DRAIN_ROUND_EN).
REQ-039 tile_count=2, shift=0; beats 0x7FFFFFF and 0x7FFFFFF -> out_data=32767; beats -0x8000000 and -1 -> out_data=-32768.
REQ-040 num_outputs=6, tile_count=1, out_ready=0 -> 4 outputs are held, in_ready drops, FSM stalls in EMIT; raise out_ready -> all 6 are delivered in order and done fires once.
REQ-041 FIFO full with out_ready=1 in an EMIT cycle -> simultaneous pop and push; occupancy stays 4 and no data is lost.
REQ-042 reset after 2 of 3 beats -> busy=0, out_valid=0, no done; a following job with beats 1, 1, 1 -> out_data=3.

Source files
------------

// File: rtl/column_output_drain.sv
`default_nettype none
// ============================================================================
// Module      : column_output_drain
// Description : Accumulates tile_count signed partial sums per output column
//               value, then scales (arithmetic right shift), optionally clamps
//               negatives to zero, saturates to OUT_W bits and pushes the
//               result into a small output FIFO. num_outputs values form a job.
//               Optional macro COLUMN_DRAIN_ROUND_EN adds round-half-up ahead
//               of the shift; without it the shift truncates toward -inf.
// Ports       : clk, reset (sync, active-high)
//               start, tile_count, num_outputs, shift_amt, relu_en : job setup
//               total_output, in_valid, in_ready : partial-sum input stream
//               out_data, out_valid, out_ready   : FIFO output stream
//               busy, done                       : job status
// Revision    : 1.0 - initial release
// ============================================================================
module column_output_drain #(
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              tile_count,
    input  logic [7:0]              num_outputs,
    input  logic [4:0]              shift_amt,
    input  logic                    relu_en,
    input  logic [27:0]             total_output,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    // Saturation bounds expressed at the widened (ACC_W+1) datapath width.
    localparam logic signed [ACC_W:0] c_sat_max =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_sat_min =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Job configuration latched at start
    logic [7:0]               r_tile_count;
    logic [7:0]               r_num_outputs;
    logic [4:0]               r_shift_amt;
    logic                     r_relu_en;

    logic [7:0]               r_beat_cnt;
    logic [7:0]               r_out_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_done;

    // FIFO storage
    logic [OUT_W-1:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_ptr_w:0]         r_count;

    logic                     w_start_ok;
    logic                     w_accept;
    logic                     w_last_beat;
    logic                     w_last_out;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;
    logic                     w_push;
    logic signed [ACC_W-1:0]  w_beat_ext;
    logic signed [ACC_W:0]    w_acc_wide;
    logic signed [ACC_W:0]    w_round_term;
    logic signed [ACC_W:0]    w_rounded;
    logic signed [ACC_W:0]    w_shifted;
    logic signed [ACC_W:0]    w_relu;
    logic [OUT_W-1:0]         w_emit_data;

    assign w_start_ok  = start && (tile_count != 8'd0) && (num_outputs != 8'd0);
    assign w_accept    = (r_state == ACCUM) && in_valid;
    assign w_last_beat = w_accept && ((r_beat_cnt + 8'd1) == r_tile_count);
    assign w_last_out  = (r_out_cnt + 8'd1) == r_num_outputs;

    assign w_full  = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push  = (r_state == EMIT) && (!w_full || w_pop);

    assign w_beat_ext = ACC_W'($signed(total_output));

    // ------------------------------------------------------------------------
    // Emit datapath: one bit of headroom so the rounding add cannot wrap.
    // ------------------------------------------------------------------------
    assign w_acc_wide = (ACC_W+1)'(r_acc);

`ifdef COLUMN_DRAIN_ROUND_EN
    assign w_round_term = (r_shift_amt != 5'd0) ?
                          ((ACC_W+1)'(1) << (r_shift_amt - 5'd1)) : '0;
`else
    assign w_round_term = '0;
`endif

    assign w_rounded = w_acc_wide + w_round_term;
    assign w_shifted = w_rounded >>> r_shift_amt;
    assign w_relu    = (r_relu_en && (w_shifted < 0)) ? '0 : w_shifted;

    always_comb begin
        w_emit_data = w_relu[OUT_W-1:0];
        if (w_relu > c_sat_max) begin
            w_emit_data = c_sat_max[OUT_W-1:0];
        end else if (w_relu < c_sat_min) begin
            w_emit_data = c_sat_min[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_push) begin
                    w_state_nxt = w_last_out ? IDLE : ACCUM;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Job control and accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile_count  <= '0;
            r_num_outputs <= '0;
            r_shift_amt   <= '0;
            r_relu_en     <= 1'b0;
            r_beat_cnt    <= '0;
            r_out_cnt     <= '0;
            r_acc         <= '0;
            r_done        <= 1'b0;
        end else begin
            r_done <= w_push && w_last_out;

            if ((r_state == IDLE) && w_start_ok) begin
                r_tile_count  <= tile_count;
                r_num_outputs <= num_outputs;
                r_shift_amt   <= shift_amt;
                r_relu_en     <= relu_en;
                r_beat_cnt    <= '0;
                r_out_cnt     <= '0;
            end

            if (w_accept) begin
                // First beat of an output loads, discarding the previous sum.
                r_acc      <= (r_beat_cnt == 8'd0) ? w_beat_ext : (r_acc + w_beat_ext);
                r_beat_cnt <= w_last_beat ? 8'd0 : (r_beat_cnt + 8'd1);
            end

            if (w_push) begin
                r_out_cnt <= r_out_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO (contents persist across jobs; only reset empties it)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_emit_data;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_column_output_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_column_output_drain
// Description : Directed self-checking bench for column_output_drain. Expected
//               outputs are queued when a job is set up and compared in order
//               as the DUT hands words to the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_column_output_drain;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  tile_count;
    logic [7:0]  num_outputs;
    logic [4:0]  shift_amt;
    logic        relu_en;
    logic [27:0] total_output;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int          checks   = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          d0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    column_output_drain dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tile_count   (tile_count),
        .num_outputs  (num_outputs),
        .shift_amt    (shift_amt),
        .relu_en      (relu_en),
        .total_output (total_output),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
            $error("check %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: shift (optionally rounded), clamp negatives, saturate to 16 bits.
    function automatic logic [31:0] model(input longint acc, input int sh, input bit relu);
        longint a;
        longint r;
        a = acc;
`ifdef COLUMN_DRAIN_ROUND_EN
        if (sh > 0) a = a + (longint'(1) <<< (sh - 1));
`endif
        r = a >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 32'(r);
    endfunction

    // Consumer-side scoreboard and done counter
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'($signed(out_data)), 32'hDEAD_BEEF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", 32'($signed(out_data)), mon_exp);
            end
        end
    end

    task automatic start_job(input int tc, input int no, input int sh, input bit relu);
        tile_count  = 8'(tc);
        num_outputs = 8'(no);
        shift_amt   = 5'(sh);
        relu_en     = relu;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input int v);
        int n;
        n = 0;
        total_output = 28'(v);
        in_valid     = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("beat_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        tile_count   = '0;
        num_outputs  = '0;
        shift_amt    = '0;
        relu_en      = 1'b0;
        total_output = '0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // start with tile_count == 0 is ignored
        start_job(0, 1, 0, 0);
        check("zero_tile_start_ignored", 32'(busy), 32'd0);

        // Basic accumulation: 10 - 4 + 7 = 13, with latency/done timing
        d0 = done_cnt;
        exp_q.push_back(model(13, 0, 0));
        start_job(3, 1, 0, 0);
        check("busy_after_start", 32'(busy), 32'd1);
        send_beat(10);
        send_beat(-4);
        send_beat(7);
        check("emit_in_ready_low",  32'(in_ready),  32'd0);
        check("emit_out_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("push_out_valid", 32'(out_valid), 32'd1);
        check("push_out_data",  32'($signed(out_data)), 32'd13);
        check("done_pulse",     32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_job", 32'(busy), 32'd0);
        wait_drain();
        check("done_count_job1", 32'(done_cnt - d0), 32'd1);

        // Shift + relu
        d0 = done_cnt;
        exp_q.push_back(model(-100, 2, 1));
        exp_q.push_back(model(7, 2, 1));
        start_job(1, 2, 2, 1);
        send_beat(-100);
        send_beat(7);
        wait_drain();
        check("done_count_relu", 32'(done_cnt - d0), 32'd1);

        // Positive saturation
        exp_q.push_back(model(2 * 64'sd134217727, 0, 0));
        start_job(2, 1, 0, 0);
        send_beat(32'h07FF_FFFF);
        send_beat(32'h07FF_FFFF);
        wait_drain();

        // Negative saturation
        exp_q.push_back(model(-64'sd134217729, 0, 0));
        start_job(2, 1, 0, 0);
        send_beat(-134217728);
        send_beat(-1);
        wait_drain();

        // Backpressure: FIFO fills, FSM stalls in EMIT, then concurrent pop+push
        d0 = done_cnt;
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) exp_q.push_back(model(i * 100, 0, 0));
        start_job(1, 6, 0, 0);
        for (int i = 1; i <= 5; i++) send_beat(i * 100);
        repeat (3) @(posedge clk);
        #1;
        check("stall_in_ready_low", 32'(in_ready),  32'd0);
        check("stall_busy",         32'(busy),      32'd1);
        check("stall_out_valid",    32'(out_valid), 32'd1);
        check("stall_head",         32'($signed(out_data)), 32'd100);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("full_pop_push_in_ready", 32'(in_ready), 32'd1);
        check("full_pop_push_head",     32'($signed(out_data)), 32'd200);
        send_beat(600);
        wait_drain();
        check("done_count_backpressure", 32'(done_cnt - d0), 32'd1);

        // Reset mid-job aborts without done
        d0 = done_cnt;
        start_job(3, 1, 0, 0);
        send_beat(5);
        send_beat(6);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",      32'(busy),      32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data",  32'(out_data),  32'd0);
        reset = 1'b0;
        // in_valid in IDLE must not be consumed
        total_output = 28'd999;
        in_valid     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("idle_ignores_in_valid", 32'(busy), 32'd0);

        d0 = done_cnt;
        exp_q.push_back(model(3, 0, 0));
        start_job(3, 1, 0, 0);
        send_beat(1);
        send_beat(1);
        send_beat(1);
        wait_drain();
        check("done_count_after_abort", 32'(done_cnt - d0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
